// File: rtl/system_reg_uart_pkg.sv
// Shared types and constants for the PIO-register-to-UART transmitter.
// Frame is 8N1: one start bit, eight data bits LSB first, one stop bit.
package system_reg_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS           = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/system_reg_uart_baud.sv
// Bit-period timer: pulses bit_end on the last clock of each bit period.
// restart realigns the period so a new frame's start bit is full length.
module system_reg_uart_baud
  import system_reg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/system_reg_uart_tx.sv
// Serialises every change of the PIO output register as one 8N1 frame on txd,
// with a one-deep pending buffer, sticky overrun flag and a frame counter.
module system_reg_uart_tx
  import system_reg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_port,
  input  logic              overrun_clr,
  output logic              txd,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frames_sent
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0] prev_q;
  logic [BW-1:0]     bit_q, bit_d;
  logic [15:0]       frames_q, frames_d;
  logic              ovr_q, ovr_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              change, restart, bit_end, stop_end, ovr_set;

  assign change   = (in_port != prev_q);
  assign stop_end = (state_q == STOP) && bit_end;

  system_reg_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      prev_q     <= '0;
      bit_q      <= '0;
      frames_q   <= '0;
      ovr_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      prev_q     <= in_port;
      bit_q      <= bit_d;
      frames_q   <= frames_d;
      ovr_q      <= ovr_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bit_d      = bit_q;
    frames_d   = frames_q;
    restart    = 1'b0;
    ovr_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (change) begin
          shift_d = in_port;
          state_d = START;
          restart = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          frames_d = frames_q + 16'd1;
          if (pend_vld_q) begin
            shift_d    = pend_q;
            pend_vld_d = 1'b0;
            state_d    = START;
            restart    = 1'b1;
          end else if (change) begin
            shift_d = in_port;
            state_d = START;
            restart = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // At the end of a frame the old pending byte has just been consumed, so a
    // coincident change refills the buffer without counting as an overrun.
    if (state_q != IDLE && change) begin
      if (stop_end) begin
        if (pend_vld_q) begin
          pend_d     = in_port;
          pend_vld_d = 1'b1;
        end
      end else begin
        ovr_set    = pend_vld_q;
        pend_d     = in_port;
        pend_vld_d = 1'b1;
      end
    end

    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != IDLE) || pend_vld_d;
    if (state_d == START) begin
      txd_d = 1'b0;
    end else if (state_d == DATA) begin
      txd_d = shift_d[0];
    end
  end

  assign txd         = txd_q;
  assign busy        = busy_q;
  assign overrun     = ovr_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_system_reg_uart_tx.sv
// Bench for system_reg_uart_tx: directed scenarios plus random register
// traffic, all outputs compared every cycle against a frame-level model.
module tb_system_reg_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_port;
  logic        overrun_clr;
  logic        txd;
  logic        busy;
  logic        overrun;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  system_reg_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .overrun_clr(overrun_clr),
    .txd        (txd),
    .busy       (busy),
    .overrun    (overrun),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is a byte plus the cycles it has been on the line.
  bit          m_valid = 1'b0;
  bit          m_active;
  int          m_elapsed;
  logic [7:0]  m_byte;
  logic [7:0]  m_pend;
  bit          m_pend_v;
  logic [7:0]  m_prev;
  bit          m_ovr;
  logic [15:0] m_frames;

  function automatic logic m_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_elapsed / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit chg;
    bit set_ovr;
    if (reset) begin
      m_valid   = 1'b1;
      m_active  = 1'b0;
      m_elapsed = 0;
      m_byte    = 8'h00;
      m_pend    = 8'h00;
      m_pend_v  = 1'b0;
      m_prev    = 8'h00;
      m_ovr     = 1'b0;
      m_frames  = 16'h0000;
    end else if (m_valid) begin
      chg     = (in_port != m_prev);
      set_ovr = 1'b0;
      if (m_active) begin
        if (m_elapsed == FRAME_CYC - 1) begin
          m_frames = m_frames + 16'd1;
          $display("frame %0d byte %02h done at %0t", m_frames, m_byte, $time);
          if (m_pend_v) begin
            m_byte    = m_pend;
            m_elapsed = 0;
            m_pend_v  = 1'b0;
            if (chg) begin
              m_pend   = in_port;
              m_pend_v = 1'b1;
            end
          end else if (chg) begin
            m_byte    = in_port;
            m_elapsed = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_elapsed++;
          if (chg) begin
            set_ovr  = m_pend_v;
            m_pend   = in_port;
            m_pend_v = 1'b1;
          end
        end
      end else if (chg) begin
        m_active  = 1'b1;
        m_byte    = in_port;
        m_elapsed = 0;
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      m_prev = in_port;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("txd", 32'(txd), 32'(m_txd()));
      check("busy", 32'(busy), 32'(m_active | m_pend_v));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("frames_sent", 32'(frames_sent), 32'(m_frames));
    end
  end

  // Waits (at negedges) until the model frame reaches a given cycle offset.
  task automatic wait_elapsed(input int target, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 4 * FRAME_CYC && !found; k++) begin
      if (m_active && m_elapsed == target) found = 1'b1;
      else @(negedge clk);
    end
    check({name, "_reached"}, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 6 * FRAME_CYC && !found; k++) begin
      @(negedge clk);
      if (busy === 1'b0) found = 1'b1;
    end
    check({name, "_idle"}, 32'(found), 32'd1);
  endtask

  initial begin
    logic [9:0] a5_line;
    int         low_cnt;
    int         rate;

    reset       = 1'b1;
    in_port     = 8'h00;
    overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Quiet register: line must stay idle.
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    check("idle_txd_low_cycles", 32'(low_cnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_frames", 32'(frames_sent), 32'd0);

    // 0xA5 frame, line sampled mid-bit against the hand-derived pattern.
    a5_line = 10'b11_0100_1010;
    in_port = 8'hA5;
    @(negedge clk);
    check("a5_start_latency", 32'(txd), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("a5_bit%0d", i), 32'(txd), 32'(a5_line[i]));
      repeat (3) @(negedge clk);
    end
    check("a5_frames", 32'(frames_sent), 32'd1);
    check("a5_busy_after", 32'(busy), 32'd0);

    // Change during data bit 2 is queued and follows back-to-back.
    in_port = 8'h00;
    wait_idle("s3_pre");
    in_port = 8'hA5;
    wait_elapsed(13, "s3_bit2");
    in_port = 8'h3C;
    wait_elapsed(FRAME_CYC - 1, "s3_stop");
    @(negedge clk);
    check("s3_b2b_start", 32'(txd), 32'd0);
    check("s3_overrun", 32'(overrun), 32'd0);
    wait_idle("s3");
    check("s3_frames", 32'(frames_sent), 32'd4);

    // Two mid-frame changes: newest wins, overrun set, then cleared.
    in_port = 8'hA5;
    wait_elapsed(8, "s4_a");
    in_port = 8'h11;
    wait_elapsed(16, "s4_b");
    in_port = 8'h22;
    @(negedge clk);
    check("s4_overrun_set", 32'(overrun), 32'd1);
    wait_idle("s4");
    check("s4_frames", 32'(frames_sent), 32'd6);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("s4_overrun_clr", 32'(overrun), 32'd0);

    // Clear coinciding with a fresh overwrite: set wins.
    in_port = 8'h77;
    wait_elapsed(8, "s4c_a");
    in_port = 8'h88;
    wait_elapsed(16, "s4c_b");
    in_port     = 8'h99;
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("s4_set_beats_clr", 32'(overrun), 32'd1);
    wait_idle("s4c");
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // Change on the final stop cycle with nothing pending.
    in_port = 8'hA5;
    wait_elapsed(FRAME_CYC - 1, "s5_stop");
    in_port = 8'h5A;
    @(negedge clk);
    check("s5_b2b_start", 32'(txd), 32'd0);
    check("s5_overrun", 32'(overrun), 32'd0);
    wait_idle("s5");
    check("s5_frames", 32'(frames_sent), 32'd10);

    // Reset during data bit 3 aborts the frame; 0x5A resent once afterwards.
    in_port = 8'hA5;
    wait_elapsed(4 * CPB + 1, "s6_bit3");
    reset   = 1'b1;
    in_port = 8'h5A;
    @(negedge clk);
    check("s6_reset_txd", 32'(txd), 32'd1);
    check("s6_reset_busy", 32'(busy), 32'd0);
    check("s6_reset_frames", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    wait_idle("s6");
    repeat (2 * FRAME_CYC) @(negedge clk);
    check("s6_single_frame", 32'(frames_sent), 32'd1);

    // Random register traffic with occasional clears and resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rate = (i < 2000) ? 16 : 64;
      reset       = ($urandom_range(999) == 0);
      overrun_clr = ($urandom_range(31) == 0);
      if ($urandom_range(rate - 1) == 0) begin
        if ($urandom_range(3) == 0) in_port = in_port;
        else in_port = 8'($urandom);
      end
    end
    reset       = 1'b0;
    overrun_clr = 1'b0;
    wait_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/system_reg_uart_tx.md
Name: system_reg_uart_tx

Overview:
- Downstream consumer of the 8-bit PIO output register (`out_port`) in the Nios system.
- Watches the register value every cycle and serialises each new value as one 8N1 UART frame on `txd`.
- Holds a 1-deep pending buffer so that a write landing mid-frame is not lost.
- Reports `busy`, a sticky `overrun` flag and a frame counter for debug/status.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
- DATA_W, 8, payload width; fixed at 8 (must match `out_port`)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_port  input  8  connected directly to the PIO register's `out_port`
- overrun_clr  input  1  single-cycle pulse; clears `overrun`
- txd  output  1  UART serial out; idle high; registered
- busy  output  1  high while a frame is on the line or a byte is pending
- overrun  output  1  sticky; a pending byte was overwritten
- frames_sent  output  16  count of completed frames; wraps 0xFFFF→0x0000

Behaviour:
- Reset (synchronous, active-high; one cycle sufficient):
  - `txd`=1, `busy`=0, `overrun`=0, `frames_sent`=0.
  - State=IDLE; pending valid cleared; `prev`=0x00; baud and bit counters cleared.
  - Reset mid-frame aborts the frame: `txd` is 1 on the edge after reset is sampled.
  - After reset releases, a nonzero `in_port` differs from `prev`=0x00 and is sent once.
- Change detect:
  - `prev` is updated to `in_port` every cycle.
  - change = (`in_port` != `prev`), evaluated before the edge.
  - A write of the same value to the PIO register produces no frame.
- States and timing:
  - IDLE: on change, load the shift register with `in_port`, go to START, drive `txd`=0 on that same edge. Latency is 1 cycle from `in_port` change to `txd` fall.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA, bit index=0.
  - DATA: `txd`=shift[0]; shift right every CLKS_PER_BIT cycles, LSB first; after bit 7 go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. On its final cycle `frames_sent` increments and:
    - if pending valid: load pending into the shift register, clear pending, go to START (back-to-back, no idle bit);
    - else if change on that same edge: load `in_port` and go to START;
    - else go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every START entry.
- Pending buffer (applies when state != IDLE):
  - A change writes `in_port` into pending and sets pending valid.
  - If pending was already valid it is overwritten (newest wins) and `overrun` is set.
  - Exception: on the final STOP cycle the pending byte is consumed first. A simultaneous change then refills pending and does not set `overrun`.
- `overrun`: set has priority over `overrun_clr` on the same edge.
- `busy` = (state != IDLE) | pending valid; registered in step with the state.
- `txd` is always driven from a flop; it is never combinational from `in_port`.

Decomposition:
- Package `system_reg_uart_pkg` holds:
  - state enum {IDLE, START, DATA, STOP};
  - `FRAME_BITS`=10;
  - `DEFAULT_CLKS_PER_BIT`=434.
- One sub-module, `system_reg_uart_baud`, owns the baud counter.
  - Inputs: `clk`, `reset`, `restart`.
  - Output: `bit_end`, a pulse on the last cycle of each bit period.
  - The FSM, shift register, pending buffer and counters stay in the top level.

Test Plan (CLKS_PER_BIT=4):
- Reset, hold `in_port`=0x00 for 100 cycles -> `txd`=1, `busy`=0, `frames_sent`=0, no transitions.
- `in_port` 0x00→0xA5 -> `txd` falls 1 cycle later; line reads 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; `busy` high for 40 cycles; `frames_sent`=1.
- Send 0xA5, change to 0x3C at data bit 2 -> 0x3C start bit begins the cycle after the 0xA5 stop ends; `overrun`=0; `frames_sent`=2.
- Send 0xA5, change to 0x11 then 0x22 mid-frame -> only 0x22 follows; `overrun`=1; `overrun_clr` pulse -> 0; `overrun_clr` on the same edge as a new overwrite -> stays 1.
- Change 0xA5→0x5A on the final STOP cycle of an idle-pending frame -> 0x5A frame is back-to-back, `overrun`=0.
- Assert `reset` during data bit 3 -> next edge `txd`=1, `busy`=0, `frames_sent`=0; after release with `in_port`=0x5A, exactly one 0x5A frame is sent.
